// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store request at a time into word-wide
// memory cycles, with read-modify-write for sub-word stores and sub-word load
// extraction. Misaligned, out-of-range and illegal requests are rejected
// without touching memory.
`timescale 1ns/1ps
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] address,
   output logic [31:0] writeData,
   input  logic [31:0] memData
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] wbuf_q, wbuf_d;

   logic        req_err_c;
   logic [32:0] req_last_c;
   logic [4:0]  shamt_c;
   logic [31:0] lane_c;
   logic [31:0] load_c;
   logic [31:0] merge_c;

   // Classify the incoming request: illegal code, misalignment or out of range.
   always_comb begin
      req_err_c  = 1'b0;
      req_last_c = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
      unique case (req_funct3)
         F3_B:    req_err_c = 1'b0;
         F3_H:    req_err_c = req_addr[0];
         F3_W:    req_err_c = (req_addr[1:0] != 2'b00);
         F3_BU:   req_err_c = req_we;
         F3_HU:   req_err_c = req_we | req_addr[0];
         default: req_err_c = 1'b1;
      endcase
      if (req_last_c >= 33'(MEM_BYTES)) req_err_c = 1'b1;
   end

   // Extract the loaded lane and build the merged word for sub-word stores.
   always_comb begin
      shamt_c = {addr_q[1:0], 3'b000};
      lane_c  = memData >> shamt_c;
      unique case (funct3_q)
         F3_B:    load_c = {{24{lane_c[7]}}, lane_c[7:0]};
         F3_H:    load_c = {{16{lane_c[15]}}, lane_c[15:0]};
         F3_W:    load_c = memData;
         F3_BU:   load_c = {24'd0, lane_c[7:0]};
         F3_HU:   load_c = {16'd0, lane_c[15:0]};
         default: load_c = 32'd0;
      endcase
      if (funct3_q == F3_H)
         merge_c = (memData & ~(32'h0000_FFFF << shamt_c)) |
                   (32'(wdata_q[15:0]) << shamt_c);
      else
         merge_c = (memData & ~(32'h0000_00FF << shamt_c)) |
                   (32'(wdata_q[7:0]) << shamt_c);
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      wbuf_d   = wbuf_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = req_err_c;
               rdata_d  = 32'd0;
               wbuf_d   = 32'd0;
               if (req_err_c)                     state_d = S_RESP;
               else if (req_we && req_funct3 == F3_W) state_d = S_WRITE;
               else                               state_d = S_READ;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            if (we_q) begin
               wbuf_d  = merge_c;
               state_d = S_WRITE;
            end else begin
               rdata_d = load_c;
               state_d = S_RESP;
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
         wbuf_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         wbuf_q   <= wbuf_d;
      end
   end

   // Outputs decoded from registers only; buses are zero when not strobed.
   assign req_ready  = (state_q == S_IDLE);
   assign memRead    = (state_q == S_READ);
   assign memWrite   = (state_q == S_WRITE);
   assign address    = (memRead || memWrite) ? {addr_q[31:2], 2'b00} : 32'd0;
   assign writeData  = memWrite ? ((funct3_q == F3_W) ? wdata_q : wbuf_q) : 32'd0;
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = resp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        memRead, memWrite;
   logic [31:0] address, writeData;
   logic [31:0] memData = 32'd0;

   int total = 0;
   int bad = 0;

   logic [31:0] mem [0:255];
   int wr_cnt = 0;
   int both_cnt = 0;

   int          r_lat, r_rd_cyc, r_wr_cyc;
   logic        r_err, r_ready;
   logic [31:0] r_rdata, r_rd_addr, r_wr_addr, r_wr_data;

   load_store_unit #(.MEM_BYTES(1024)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .memRead(memRead), .memWrite(memWrite), .address(address),
      .writeData(writeData), .memData(memData)
   );

   always #5 clk = ~clk;

   // Word memory: one-cycle registered read, full-word write.
   always @(posedge clk) begin
      if (memRead) memData <= mem[address[9:2]];
      if (memWrite) begin
         mem[address[9:2]] <= writeData;
         wr_cnt = wr_cnt + 1;
      end
   end

   always @(negedge clk) if (memRead && memWrite) both_cnt = both_cnt + 1;

   // Drive one request and record strobes and response, cycles counted from acceptance.
   task automatic run_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
      r_lat = -1; r_rd_cyc = -1; r_wr_cyc = -1;
      r_err = 1'b0; r_rdata = 32'd0; r_rd_addr = 32'd0;
      r_wr_addr = 32'd0; r_wr_data = 32'd0;
      @(negedge clk);
      r_ready = req_ready;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (memRead && r_rd_cyc < 0) begin r_rd_cyc = c; r_rd_addr = address; end
         if (memWrite && r_wr_cyc < 0) begin
            r_wr_cyc = c; r_wr_addr = address; r_wr_data = writeData;
         end
         if (resp_valid) begin r_lat = c; r_err = resp_err; r_rdata = resp_rdata; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      total++; if ({memRead, memWrite, resp_valid, resp_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes got=%b exp=0000", {memRead, memWrite, resp_valid, resp_err}); end
      total++; if ({address, writeData, resp_rdata} !== 96'd0) begin
         bad++; $display("FAIL reset_buses got=%h exp=0", {address, writeData, resp_rdata}); end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_sw();
      run_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
      total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", r_ready); end
      total++; if (r_wr_cyc !== 1) begin bad++; $display("FAIL sw_wr_cycle got=%0d exp=1", r_wr_cyc); end
      total++; if (r_wr_addr !== 32'h8) begin bad++; $display("FAIL sw_addr got=%h exp=8", r_wr_addr); end
      total++; if (r_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_data got=%h exp=deadbeef", r_wr_data); end
      total++; if (r_rd_cyc !== -1) begin bad++; $display("FAIL sw_no_read got=%0d exp=-1", r_rd_cyc); end
      total++; if (r_lat !== 2 || r_err !== 1'b0 || r_rdata !== 32'd0) begin
         bad++; $display("FAIL sw_resp got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=0", r_lat, r_err, r_rdata); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [31:0] ad [5] = '{32'h9, 32'h9, 32'hA, 32'hA, 32'h8};
      logic [31:0] ex [5] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, f3[i], ad[i], 32'd0);
         total++; if (r_rdata !== ex[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, r_rdata, ex[i]); end
         total++; if (r_lat !== 3 || r_err !== 1'b0) begin
            bad++; $display("FAIL load%0d_resp got lat=%0d err=%b exp lat=3 err=0", i, r_lat, r_err); end
         total++; if (r_rd_cyc !== 1 || r_rd_addr !== 32'h8 || r_wr_cyc !== -1) begin
            bad++; $display("FAIL load%0d_mem got rd=%0d addr=%h wr=%0d exp rd=1 addr=8 wr=-1", i, r_rd_cyc, r_rd_addr, r_wr_cyc); end
      end
   endtask

   task automatic test_rmw();
      run_req(1'b1, 3'b000, 32'hB, 32'h12);
      total++; if (r_rd_cyc !== 1 || r_rd_addr !== 32'h8) begin
         bad++; $display("FAIL sb_read got cyc=%0d addr=%h exp cyc=1 addr=8", r_rd_cyc, r_rd_addr); end
      total++; if (r_wr_cyc !== 3 || r_wr_addr !== 32'h8 || r_wr_data !== 32'h12ADBEEF) begin
         bad++; $display("FAIL sb_write got cyc=%0d addr=%h data=%h exp cyc=3 addr=8 data=12adbeef", r_wr_cyc, r_wr_addr, r_wr_data); end
      total++; if (r_lat !== 4 || r_err !== 1'b0 || r_rdata !== 32'd0) begin
         bad++; $display("FAIL sb_resp got lat=%0d err=%b rdata=%h exp lat=4 err=0 rdata=0", r_lat, r_err, r_rdata); end
      run_req(1'b1, 3'b001, 32'h8, 32'h5555);
      total++; if (r_wr_data !== 32'h12AD5555 || r_lat !== 4) begin
         bad++; $display("FAIL sh_write got data=%h lat=%0d exp data=12ad5555 lat=4", r_wr_data, r_lat); end
      total++; if (mem[2] !== 32'h12AD5555) begin bad++; $display("FAIL sh_memory got=%h exp=12ad5555", mem[2]); end
   endtask

   task automatic test_errors();
      logic        we [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3 [5] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b010};
      logic [31:0] ad [5] = '{32'h5, 32'h6, 32'h2, 32'h0, 32'h400};
      for (int i = 0; i < 5; i++) begin
         run_req(we[i], f3[i], ad[i], 32'hFFFFFFFF);
         total++; if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0) begin
            bad++; $display("FAIL err%0d_resp got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", i, r_lat, r_err, r_rdata); end
         total++; if (r_rd_cyc !== -1 || r_wr_cyc !== -1) begin
            bad++; $display("FAIL err%0d_strobes got rd=%0d wr=%0d exp rd=-1 wr=-1", i, r_rd_cyc, r_wr_cyc); end
      end
      run_req(1'b0, 3'b010, 32'h3FC, 32'd0);
      total++; if (r_lat !== 3 || r_err !== 1'b0 || r_rdata !== 32'h0BADF00D) begin
         bad++; $display("FAIL lw_top got lat=%0d err=%b rdata=%h exp lat=3 err=0 rdata=0badf00d", r_lat, r_err, r_rdata); end
   endtask

   task automatic test_async_reset();
      int wc0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #2;
      wc0 = wr_cnt;
      reset = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1 || memRead !== 1'b0 || memWrite !== 1'b0 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL async_reset_outputs got ready=%b rd=%b wr=%b rv=%b exp 1 0 0 0", req_ready, memRead, memWrite, resp_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      total++; if (wr_cnt !== wc0) begin bad++; $display("FAIL async_reset_no_write got=%0d exp=%0d", wr_cnt, wc0); end
      total++; if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL async_reset_mem got=%h exp=cafef00d", mem[4]); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready got=%b exp=1", req_ready); end
      run_req(1'b0, 3'b010, 32'h10, 32'd0);
      total++; if (r_lat !== 3 || r_rdata !== 32'hCAFEF00D) begin
         bad++; $display("FAIL post_reset_lw got lat=%0d rdata=%h exp lat=3 rdata=cafef00d", r_lat, r_rdata); end
   endtask

   task automatic test_back_to_back();
      logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0]  f3 [4] = '{3'b010, 3'b010, 3'b100, 3'b001};
      logic [31:0] ad [4] = '{32'h20, 32'h20, 32'h21, 32'h22};
      logic [31:0] wd [4] = '{32'h11223344, 32'h0, 32'h0, 32'h0};
      logic [31:0] ex [4] = '{32'h0, 32'h11223344, 32'h00000033, 32'h00001122};
      int rsp_cyc [4] = '{2, 6, 10, 14};
      int acc_cyc [4] = '{0, 3, 7, 11};
      int idx = 0;
      int nresp = 0;
      int ready_err = 0;
      logic acc, exp_ready;
      @(negedge clk);
      req_valid = 1'b1; req_we = we[0]; req_funct3 = f3[0]; req_addr = ad[0]; req_wdata = wd[0];
      for (int c = 0; c < 20; c++) begin
         acc = req_ready && req_valid;
         exp_ready = (c == 0 || c == 3 || c == 7 || c == 11 || c >= 15);
         if (req_ready !== exp_ready) ready_err++;
         if (resp_valid && nresp < 4) begin
            total++; if (c !== rsp_cyc[nresp] || resp_err !== 1'b0 || resp_rdata !== ex[nresp]) begin
               bad++; $display("FAIL b2b_resp%0d got cyc=%0d err=%b rdata=%h exp cyc=%0d err=0 rdata=%h",
                               nresp, c, resp_err, resp_rdata, rsp_cyc[nresp], ex[nresp]); end
            nresp++;
         end
         if (acc && idx < 4) begin
            total++; if (c !== acc_cyc[idx]) begin
               bad++; $display("FAIL b2b_accept%0d got cyc=%0d exp=%0d", idx, c, acc_cyc[idx]); end
            idx++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (idx < 4) begin
               req_we = we[idx]; req_funct3 = f3[idx]; req_addr = ad[idx]; req_wdata = wd[idx];
            end else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      total++; if (idx !== 4 || nresp !== 4) begin
         bad++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 4 4", idx, nresp); end
      total++; if (ready_err !== 0) begin bad++; $display("FAIL b2b_ready got=%0d exp=0", ready_err); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[4]   = 32'hCAFEF00D;
      mem[255] = 32'h0BADF00D;
      test_reset();
      test_sw();
      test_loads();
      test_rmw();
      test_errors();
      test_async_reset();
      test_back_to_back();
      total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the multicycle core datapath and the unified byte-addressed memory. It takes one load or store request at a time, with a funct3 size code, and turns it into word-wide memRead/memWrite cycles. The memory has a registered, one-cycle read and writes only full 4-byte words. Sub-word stores are done as read-modify-write. The block also extracts and sign- or zero-extends sub-word loads, and rejects misaligned, out-of-range or illegal requests without touching memory.

Parameters:
MEM_BYTES, 1024, memory size in bytes; a request is in range when aligned_addr + 3 < MEM_BYTES.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 size/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid; 1 = request rejected
resp_rdata  output  32  load result (0 for stores and errors)
memRead  output  1  to memory; its memData is valid the cycle after
memWrite  output  1  to memory; writes 4 bytes at address
address  output  32  to memory; always aligned_addr = {addr[31:2], 2'b00}
writeData  output  32  to memory
memData  input  32  from memory, little-endian word

Behaviour:
- Reset (async, any state): state goes to IDLE. All outputs are 0 except req_ready = 1. All latched request registers are cleared. If reset arrives mid-RMW, the memory write is never issued.
- Legal funct3 codes:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other code is illegal.
- Error when any of these hold: illegal funct3; halfword with addr[0] = 1; word with addr[1:0] != 0; aligned_addr + 3 >= MEM_BYTES.
- States and transitions:
  - IDLE: req_ready = 1. On req_valid, latch we, funct3, addr, wdata, then go to:
    - RESP with the error flag set, if the request is in error;
    - WRITE, for SW;
    - READ, for everything else.
  - READ: memRead = 1, address = aligned_addr. Next state WAIT.
  - WAIT: memData is valid this cycle.
    - Load: register the extracted result into resp_rdata, go to RESP.
    - SB/SH: register the merged word into the write buffer, go to WRITE.
  - WRITE: memWrite = 1, address = aligned_addr. writeData = latched wdata for SW, write buffer for SB/SH. Next state RESP.
  - RESP: resp_valid = 1 for exactly one cycle, resp_err as computed. Next state IDLE.
- Memory-side outputs:
  - Decoded from state registers only, so they are glitch-free.
  - memRead and memWrite are never high together.
  - address and writeData are 0 when the corresponding strobe is low.
- Load extraction (byte offset b = addr[1:0]):
  - byte = memData[8b+7:8b]; halfword = memData[8b+15:8b], with b in {0, 2}.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store merge: replace only the target byte or halfword lanes of memData with req_wdata[7:0] or [15:0]. All other lanes are preserved.
- Latency, counted from the acceptance cycle (0) to resp_valid:
  - loads: 3
  - SW: 2
  - SB/SH: 4
  - error: 1, with no memory strobes.
- req_valid while not IDLE is ignored; there is no queueing. Back-to-back requests: the next one is accepted in the IDLE cycle after RESP.
- There is no response backpressure; the core must be waiting for the pulse.

Test Plan:
1. SW addr 0x8, wdata 0xDEADBEEF:
   - cycle 1: memWrite = 1, address 0x8, writeData 0xDEADBEEF, memRead = 0;
   - cycle 2: resp_valid = 1, resp_err = 0, resp_rdata = 0.
2. After test 1, loads return:
   - LB 0x9 → 0xFFFFFFBE; LBU 0x9 → 0x000000BE;
   - LH 0xA → 0xFFFFDEAD; LHU 0xA → 0x0000DEAD; LW 0x8 → 0xDEADBEEF;
   - each has memRead at cycle 1 with address 0x8, and resp at cycle 3.
3. SB addr 0xB, wdata 0x12 over 0xDEADBEEF:
   - READ then WRITE of 0x12ADBEEF to address 0x8; resp at cycle 4.
   - SH 0x8, wdata 0x5555 then writes 0x12AD5555.
4. Errors, each giving resp_valid with resp_err = 1 at cycle 1, rdata 0 and no memRead/memWrite:
   - LH 0x5; LW 0x6; SW 0x2; funct3 011;
   - LW 0x400 (MEM_BYTES 1024). LW 0x3FC, by contrast, succeeds.
5. Assert reset asynchronously (mid-cycle) while SB 0x10 is in WAIT:
   - outputs clear immediately, memWrite never asserts, memory word at 0x10 is unchanged;
   - after reset deasserts, req_ready = 1 and a new LW completes normally.
6. Hold req_valid high with alternating requests:
   - req_valid asserted while busy is ignored;
   - each accept occurs exactly one cycle after the previous resp_valid;
   - req_ready = 0 in READ/WAIT/WRITE/RESP.
